// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
//   boot_state_t   : loader FSM states
//   state_accepts  : true for states that take words from the stream
package boot_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        LOAD = 3'd1,
        CSUM = 3'd2,
        HOLD = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } boot_state_t;

    function automatic logic state_accepts(input boot_state_t s);
        return (s == HDR) || (s == LOAD) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader sitting in front of the 5-stage RISC-V core.
// Takes a framed program image from a valid/ready word stream
// (header N, N payload words, checksum word), writes the payload into
// instruction memory, checks the additive checksum, and holds the core in
// reset until the image is verified.
//
// Ports
//   clk, rst                     single clock, synchronous active-high reset
//   s_valid/s_ready/s_data       input word stream
//   imem_we/imem_addr/imem_wdata instruction memory write port (byte address)
//   cpu_rst_n                    active-low reset to the core
//   boot_done                    image verified, core running (sticky)
//   boot_err                     oversize header or bad checksum (sticky)
//
// state | meaning
// ------+------------------------------------------------------------
// HDR   | waiting for the header word (payload word count N)
// LOAD  | accepting payload words and writing them to imem
// CSUM  | waiting for the checksum word
// HOLD  | checksum good, core still held in reset for RST_HOLD cycles
// RUN   | core released, boot complete
// ERR   | oversize header or checksum mismatch, core held in reset
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DAT_WIDTH  = 32,
    parameter int unsigned             DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter int unsigned             RST_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DAT_WIDTH-1:0]  s_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DAT_WIDTH-1:0]  imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  boot_done,
    output logic                  boot_err
);

    // idx must be able to reach DEPTH itself so a full image never wraps.
    localparam int IDX_W  = $clog2(DEPTH + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    boot_state_t          state;
    boot_state_t          state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     n_words;
    logic [DAT_WIDTH-1:0] sum;
    logic [HOLD_W-1:0]    hold_cnt;

    logic                 xfer;
    logic                 hdr_too_big;
    logic                 hdr_empty;
    logic                 last_word;
    logic                 csum_ok;

    assign xfer        = s_valid && s_ready;
    assign hdr_too_big = s_data > DAT_WIDTH'(DEPTH);
    assign hdr_empty   = (s_data == '0);
    assign last_word   = (idx == (n_words - IDX_W'(1)));
    assign csum_ok     = (s_data == sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR: begin
                if (xfer) begin
                    if (hdr_too_big) begin
                        state_nxt = ERR;
                    end else if (hdr_empty) begin
                        state_nxt = CSUM;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer && last_word) begin
                    state_nxt = CSUM;
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_nxt = csum_ok ? HOLD : ERR;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = RUN;
                end
            end
            RUN:     state_nxt = RUN;
            ERR:     state_nxt = ERR;
            default: state_nxt = HDR;
        endcase
    end

    // s_ready is registered from the next state so it drops on the very
    // cycle the FSM leaves the accepting states and never handshakes a
    // word in HOLD/RUN/ERR. The status outputs follow the current state,
    // which puts the core release RST_HOLD+1 edges after the checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            n_words    <= '0;
            sum        <= '0;
            hold_cnt   <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            s_ready   <= state_accepts(state_nxt);
            imem_we   <= 1'b0;
            cpu_rst_n <= (state == RUN);
            boot_done <= (state == RUN);
            boot_err  <= (state == ERR);

            case (state)
                HDR: begin
                    if (xfer) begin
                        // Upper bits only matter for the oversize check.
                        n_words <= s_data[IDX_W-1:0];
                        idx     <= '0;
                        sum     <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        idx        <= idx + IDX_W'(1);
                        sum        <= sum + s_data;
                        imem_we    <= 1'b1;
                        imem_addr  <= BASE_ADDR + (ADDR_WIDTH'(idx) << 2);
                        imem_wdata <= s_data;
                    end
                end
                CSUM: begin
                    if (xfer && csum_ok) begin
                        hold_cnt <= HOLD_W'(RST_HOLD - 1);
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned DEPTH    = 1024;
    localparam logic [31:0] BASE     = 32'h0;
    localparam int unsigned RST_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cpu_rst_n;
    logic          boot_done;
    logic          boot_err;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    logic [31:0] last_addr = '0;

    logic [63:0] wq[$];     // expected writes {addr, data}
    logic [31:0] img[$];    // payload of the image being sent

    imem_boot_loader #(
        .ADDR_WIDTH (AW),
        .DAT_WIDTH  (DW),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (BASE),
        .RST_HOLD   (RST_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest expected write.
    always @(posedge clk) begin
        logic [63:0] e;
        #1;
        if (imem_we === 1'b1) begin
            pulse_cnt++;
            last_addr = imem_addr;
            if (wq.size() == 0) begin
                chk("write_expected", 32'(wq.size()), 32'd1);
            end else begin
                e = wq.pop_front();
                chk("imem_addr", imem_addr, e[63:32]);
                chk("imem_wdata", imem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Present one word; returns just after the edge on which it transferred.
    task automatic xfer(input logic [31:0] w, input bit payload, input logic [31:0] addr);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
            s_valid = 1'b0;
            return;
        end
        if (payload) wq.push_back({addr, w});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    function automatic logic [31:0] img_sum();
        logic [31:0] s = '0;
        foreach (img[i]) s += img[i];
        return s;
    endfunction

    task automatic load_image(input logic [31:0] csum, input bit gaps);
        xfer(32'(img.size()), 1'b0, '0);
        foreach (img[i]) begin
            if (gaps && $urandom_range(0, 1) == 1) idle();
            xfer(img[i], 1'b1, BASE + 32'(i) * 4);
        end
        xfer(csum, 1'b0, '0);
        idle();
    endtask

    task automatic check_release(input string tag);
        for (int k = 1; k <= int'(RST_HOLD) + 1; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, (k == int'(RST_HOLD) + 1) ? 32'd1 : 32'd0);
        end
        chk({tag, "_boot_done"}, {31'd0, boot_done}, 32'd1);
        chk({tag, "_boot_err"}, {31'd0, boot_err}, 32'd0);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_pending_writes"}, 32'(wq.size()), 32'd0);
    endtask

    task automatic check_error(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_boot_err"}, {31'd0, boot_err}, 32'd1);
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_boot_done"}, {31'd0, boot_done}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", imem_addr, BASE);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
        chk("rst_boot_err", {31'd0, boot_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, s_ready}, 32'd1);
        wq.delete();
    endtask

    initial begin
        int p0;

        // Basic three-word program, checksum computed from the payload.
        do_reset();
        img = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        p0 = pulse_cnt;
        load_image(img_sum(), 1'b0);
        check_release("basic");
        chk("basic_pulses", 32'(pulse_cnt - p0), 32'd3);

        // Same program, wrong checksum.
        do_reset();
        p0 = pulse_cnt;
        load_image(32'hDEAD_BEEF, 1'b0);
        check_error("badsum");
        chk("badsum_pulses", 32'(pulse_cnt - p0), 32'd3);

        // Empty image.
        do_reset();
        img = {};
        p0 = pulse_cnt;
        load_image(32'h0, 1'b0);
        check_release("empty");
        chk("empty_pulses", 32'(pulse_cnt - p0), 32'd0);

        // Oversize header.
        do_reset();
        p0 = pulse_cnt;
        xfer(DEPTH + 1, 1'b0, '0);
        idle();
        check_error("oversize");
        chk("oversize_pulses", 32'(pulse_cnt - p0), 32'd0);

        // 16-word image with random valid gaps.
        do_reset();
        img = {};
        for (int i = 0; i < 16; i++) img.push_back($urandom());
        p0 = pulse_cnt;
        load_image(img_sum(), 1'b1);
        check_release("gaps");
        chk("gaps_pulses", 32'(pulse_cnt - p0), 32'd16);

        // Reset in the same cycle as payload word 2 of 5.
        do_reset();
        p0 = pulse_cnt;
        xfer(32'd5, 1'b0, '0);
        xfer(32'h1111_0000, 1'b1, BASE);
        xfer(32'h2222_0000, 1'b1, BASE + 4);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'h3333_0000;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_pulses", 32'(pulse_cnt - p0), 32'd2);
        chk("midrst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("midrst_ready", {31'd0, s_ready}, 32'd1);
        img = '{32'hCAFE_0001, 32'hCAFE_0002};
        p0 = pulse_cnt;
        load_image(img_sum(), 1'b0);
        check_release("reload");
        chk("reload_pulses", 32'(pulse_cnt - p0), 32'd2);
        chk("reload_last_addr", last_addr, BASE + 4);

        // Full-depth image.
        do_reset();
        img = {};
        for (int i = 0; i < int'(DEPTH); i++) img.push_back(32'h1000_0000 + 32'(i) * 7);
        p0 = pulse_cnt;
        load_image(img_sum(), 1'b0);
        check_release("full");
        chk("full_pulses", 32'(pulse_cnt - p0), DEPTH);
        chk("full_last_addr", last_addr, BASE + 4 * (DEPTH - 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
